uart_frame_decoder: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_frame_buf.sv | 43 ++++
 rtl/uart_frame_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the UART frame decoder slice.
//   state_t           - decoder FSM state encoding (ST_SYNC .. ST_OUTPUT)
//   N_STATES          - number of FSM states
//   DEFAULT_SYNC_BYTE - default frame start marker
//   CHK_W             - checksum accumulator width
//   addr_w()          - address width for a register array of a given depth
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  localparam int unsigned N_STATES          = 5;
  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned CHK_W             = 8;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: DEPTH x 8 simple dual-port register array holding one
// frame's payload.
//   clk, rst  - clock, synchronous active-high reset (clears read register)
//   i_we      - write enable, i_waddr / i_wdata write address / data
//   i_re      - read enable, i_raddr read address
//   o_rdata   - registered read data; only changes on a clock with i_re=1,
//               so the consumer can hold it indefinitely under back-pressure
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: store-and-forward deframer behind the UART receiver.
// Hunts for SYNC_BYTE, takes a length byte, buffers the payload, verifies
// an 8-bit zero-sum checksum (len + payload + chk == 0) and only then
// replays the payload as a valid/ready/last stream. Bad frames are dropped
// with a one-cycle error pulse.
//   clk, rst        - clock, synchronous active-high reset
//   s_valid/s_data/s_ready - byte stream in (s_ready low only while replaying)
//   m_valid/m_data/m_last/m_ready - payload stream out
//   err_len         - pulse: length byte 0 or above MAX_LEN
//   err_chk         - pulse: checksum mismatch
//   err_timeout     - pulse: inter-byte timeout mid-frame
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables the inter-byte idle
// timeout (TIMEOUT_CYCLES); when undefined err_timeout is tied low and the
// decoder waits indefinitely mid-frame.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout
);

  localparam int unsigned      PTR_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned      AW        = addr_w(MAX_LEN);
  localparam logic [8:0]       MAX_LEN_V = 9'(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("uart_frame_decoder: MAX_LEN must be 1..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_frame_decoder: TIMEOUT_CYCLES must be at least 2");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_last_idx;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CHK_W-1:0] r_acc;
  logic             r_m_valid;
  logic             r_m_last;
  logic             r_err_len;
  logic             r_err_chk;

  logic             w_s_ready;
  logic             w_accept;
  logic             w_xfer;
  logic             w_len_bad;
  logic             w_chk_ok;
  logic             w_pay_done;
  logic             w_out_done;
  logic             w_timeout;

  logic             w_buf_we;
  logic             w_buf_re;
  logic [AW-1:0]    w_buf_raddr;
  logic [7:0]       w_buf_rdata;

  assign w_s_ready  = (r_state != ST_OUTPUT);
  assign w_accept   = s_valid & w_s_ready;
  assign w_xfer     = r_m_valid & m_ready;
  assign w_len_bad  = (s_data == 8'd0) || ({1'b0, s_data} > MAX_LEN_V);
  assign w_chk_ok   = ((r_acc + s_data) == '0);
  assign w_pay_done = (r_wr_ptr == r_last_idx);
  assign w_out_done = w_xfer & r_m_last;
  assign w_rd_nxt   = r_rd_ptr + PTR_ONE;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_SYNC: begin
        if (w_accept && (s_data == SYNC_BYTE)) w_state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (w_accept) w_state_nxt = w_len_bad ? ST_SYNC : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_accept && w_pay_done) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_accept) w_state_nxt = w_chk_ok ? ST_OUTPUT : ST_SYNC;
      end
      ST_OUTPUT: begin
        if (w_out_done) w_state_nxt = ST_SYNC;
      end
      default: w_state_nxt = ST_SYNC;
    endcase
    if (w_timeout) w_state_nxt = ST_SYNC;
  end

  // Frame datapath: length, pointers, checksum, output handshake, errors.
  // r_last_idx holds len-1 so both the write and read sides compare the
  // current pointer against it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_idx <= '0;
      r_acc      <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_chk  <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      r_err_chk <= 1'b0;
      unique case (r_state)
        ST_LEN: begin
          if (w_accept) begin
            r_acc      <= s_data;
            r_wr_ptr   <= '0;
            r_last_idx <= PTR_W'(s_data - 8'd1);
            r_err_len  <= w_len_bad;
          end
        end
        ST_PAYLOAD: begin
          if (w_accept) begin
            r_acc    <= r_acc + s_data;
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
          end
        end
        ST_CHECK: begin
          if (w_accept) begin
            if (w_chk_ok) begin
              r_m_valid <= 1'b1;
              r_m_last  <= (r_last_idx == '0);
              r_rd_ptr  <= '0;
            end else begin
              r_err_chk <= 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (w_xfer) begin
            if (r_m_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
            end else begin
              r_rd_ptr <= w_rd_nxt;
              r_m_last <= (w_rd_nxt == r_last_idx);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read-ahead: the first beat is fetched on the checksum handshake and each
  // following beat on the transfer of the previous one, so the registered
  // read data is the presented beat and stays put while stalled.
  assign w_buf_we    = (r_state == ST_PAYLOAD) && w_accept;
  assign w_buf_re    = ((r_state == ST_CHECK) && w_accept && w_chk_ok) ||
                       ((r_state == ST_OUTPUT) && w_xfer && !r_m_last);
  assign w_buf_raddr = (r_state == ST_CHECK) ? '0 : w_rd_nxt[AW-1:0];

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_buf_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (s_data),
    .i_re    (w_buf_re),
    .i_raddr (w_buf_raddr),
    .o_rdata (w_buf_rdata)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TW = addr_w(TIMEOUT_CYCLES);

  logic [TW-1:0] r_idle;
  logic          r_err_timeout;
  logic          w_in_frame;

  assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                      (r_state == ST_CHECK);
  assign w_timeout  = w_in_frame && !w_accept &&
                      (r_idle == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter restarts on every accepted byte and on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (!w_in_frame || w_accept || (w_state_nxt != r_state)) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + TW'(1);
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = w_buf_rdata;
  assign m_last  = r_m_last;
  assign err_len = r_err_len;
  assign err_chk = r_err_chk;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: scoreboard bench for uart_frame_decoder.
// Stimulus pushes expected events (payload beats / error pulses) derived from
// a byte-list frame parser; a negedge monitor pops and compares whatever the
// DUT presents. Build with UART_FRAME_TIMEOUT_EN to include the timeout case.
module tb_uart_frame_decoder;

  localparam int unsigned MAX_LEN = 64;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int unsigned TMO     = 100;

  localparam logic [1:0] K_BEAT = 2'd0;
  localparam logic [1:0] K_LEN  = 2'd1;
  localparam logic [1:0] K_CHK  = 2'd2;
  localparam logic [1:0] K_TMO  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;

  exp_t        exp_q [$];
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned beat_cnt  = 0;
  int unsigned rdy_mode  = 0; // 0 random, 1 pattern, 2 force 1, 3 force 0

  uart_frame_decoder #(
    .MAX_LEN        (MAX_LEN),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .err_len     (err_len),
    .err_chk     (err_chk),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic exp_t mk(input logic [1:0] k, input logic [7:0] d,
                              input logic l);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.last = l;
    return e;
  endfunction

  // Reference: scan a byte list for complete frames and list their outcomes
  task automatic model_frames(input bq_t q);
    int unsigned i, len, sum;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != SYNC) begin
        i++;
      end else if (i + 1 >= q.size()) begin
        i = q.size();
      end else begin
        len = q[i+1];
        if (len == 0 || len > MAX_LEN) begin
          exp_q.push_back(mk(K_LEN, 8'h00, 1'b0));
          i += 2;
        end else if (i + 2 + len >= q.size()) begin
          i = q.size();
        end else begin
          sum = len;
          for (int unsigned k = 0; k <= len; k++) sum += q[i+2+k];
          if (sum % 256 == 0) begin
            for (int unsigned k = 0; k < len; k++)
              exp_q.push_back(mk(K_BEAT, q[i+2+k], (k == len - 1)));
          end else begin
            exp_q.push_back(mk(K_CHK, 8'h00, 1'b0));
          end
          i += 3 + len;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned waited;
    logic ok;
    waited = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    while (!ok) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
      end else begin
        waited++;
        if (waited > 2000) begin
          total_cnt++;
          $display("FAIL s_ready_wait: s_ready=0 for %0d cycles, expected 1", waited);
          ok = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_burst(input bq_t q, input int unsigned gap_max);
    model_frames(q);
    foreach (q[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_byte(q[i]);
    end
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  function automatic bq_t make_frame(input int unsigned len, input logic bad_chk);
    bq_t f;
    int unsigned sum;
    logic [7:0] b;
    f = {};
    f.push_back(SYNC);
    f.push_back(8'(len));
    sum = len;
    for (int unsigned k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
      sum += b;
    end
    sum = (256 - (sum % 256)) % 256;
    if (bad_chk) sum = (sum + $urandom_range(1, 255)) % 256;
    f.push_back(8'(sum));
    return f;
  endfunction

  // m_ready driver
  initial begin
    logic pat [6];
    int unsigned pidx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pidx = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = ($urandom_range(0, 3) != 0);
        1: begin
          m_ready = pat[pidx];
          pidx = (pidx + 1) % 6;
        end
        2: m_ready = 1'b1;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       stall_prev, last_prev;
    logic [7:0] stall_data;
    logic       stall_last;
    exp_t       e;
    stall_prev = 1'b0;
    last_prev  = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        last_prev  = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, stall_data);
          chk("hold_last", m_last, stall_last);
        end
        if (last_prev) begin
          chk("post_last_valid", m_valid, 0);
          chk("post_last_s_ready", s_ready, 1);
        end
        if (m_valid) chk("s_ready_in_output", s_ready, 0);
        if (m_valid && (err_len || err_chk || err_timeout))
          chk("err_with_valid", {err_len, err_chk, err_timeout}, 0);
        if (m_valid && m_ready) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL beat_unexpected: got data %0h last %0b, expected no beat", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            chk("beat_kind", K_BEAT, e.kind);
            chk("beat_data", m_data, e.data);
            chk("beat_last", m_last, e.last);
          end
        end
        if (err_len || err_chk || err_timeout) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL err_unexpected: got len/chk/tmo %0b%0b%0b, expected none",
                     err_len, err_chk, err_timeout);
          end else begin
            e = exp_q.pop_front();
            chk("err_kind",
                err_len ? K_LEN : (err_chk ? K_CHK : K_TMO), e.kind);
          end
        end
        stall_prev = m_valid & ~m_ready;
        stall_data = m_data;
        stall_last = m_last;
        last_prev  = m_valid & m_ready & m_last;
      end
    end
  end

  // Stimulus
  initial begin
    bq_t q;
    int unsigned base, n, len, r;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_errs", {err_len, err_chk, err_timeout}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    rdy_mode = 2;
    q = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_burst(q, 0);
    drain("good3");

    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_burst(q, 0);
    q = '{8'hA5, 8'h01, 8'h5A, 8'hA6};
    send_burst(q, 0);
    q = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    send_burst(q, 0);
    drain("chk_err");

    q = '{8'hA5, 8'h00};
    send_burst(q, 0);
    q = '{8'hA5, 8'h41};
    send_burst(q, 0);
    send_burst(make_frame(MAX_LEN, 1'b0), 0);
    drain("len_bounds");

    rdy_mode = 1;
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_burst(q, 0);
    drain("backpressure");

    // Reset after two payload beats have transferred
    rdy_mode = 2;
    base = beat_cnt;
    send_burst(make_frame(6, 1'b0), 0);
    n = 0;
    while (beat_cnt < base + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("rst_test_two_beats", beat_cnt - base, 2);
    #2;
    rst = 1'b1;
    rdy_mode = 3;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("after_rst_m_valid", m_valid, 0);
    chk("after_rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_burst(make_frame(4, 1'b0), 1);
    drain("after_rst");

`ifdef UART_FRAME_TIMEOUT_EN
    q = '{8'hA5, 8'h02, 8'h11};
    send_burst(q, 0);
    exp_q.push_back(mk(K_TMO, 8'h00, 1'b0));
    repeat (TMO) @(posedge clk);
    #1;
    drain("timeout");
`endif

    // Randomized frames with noise, errors and gaps
    for (int unsigned f = 0; f < 40; f++) begin
      q = {};
      repeat ($urandom_range(0, 2)) begin
        r = $urandom_range(0, 255);
        q.push_back((8'(r) == SYNC) ? 8'h00 : 8'(r));
      end
      r = $urandom_range(0, 9);
      len = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 8)
                                       : $urandom_range(1, MAX_LEN);
      if (r == 0) begin
        q.push_back(SYNC);
        q.push_back(($urandom_range(0, 1) == 0) ? 8'h00
                                                : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        q = {q, make_frame(len, (r < 3))};
      end
      send_burst(q, 3);
    end
    drain("random");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
